// File: rtl/spi_frame_slave.sv
// SPI mode-0 frame slave: 8-bit command (W flag + 7-bit op) then 16 data bits,
// issuing a one-cycle register write strobe and shifting read data out on MISO.
module spi_frame_slave #(
    parameter int SYNC_STAGES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        spi_sck,
    input  logic        spi_cs_n,
    input  logic        spi_mosi,
    output logic        spi_miso,
    output logic        spi_wr,
    output logic [6:0]  spi_op,
    output logic [15:0] spi_din,
    input  logic        spi_ack,
    input  logic [15:0] spi_dout,
    output logic        frame_err
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] CMD  = 2'd1;
    localparam logic [1:0] DATA = 2'd2;
    localparam logic [1:0] HOLD = 2'd3;

    logic [SYNC_STAGES-1:0] sck_sync;
    logic [SYNC_STAGES-1:0] cs_sync;
    logic [SYNC_STAGES-1:0] mosi_sync;
    logic [SYNC_STAGES-1:0] sync_full;
    logic                   sck_prev;
    logic                   armed;

    logic [1:0]  state;
    logic [4:0]  bit_cnt;
    logic [7:0]  cmd_sr;
    logic [15:0] data_sr;
    logic [15:0] miso_sr;

    logic sck_s;
    logic cs_s;
    logic mosi_s;
    logic sck_rise;
    logic sck_fall;

    assign sck_s    = sck_sync[SYNC_STAGES-1];
    assign cs_s     = cs_sync[SYNC_STAGES-1];
    assign mosi_s   = mosi_sync[SYNC_STAGES-1];
    assign sck_rise = sck_s & ~sck_prev;
    assign sck_fall = ~sck_s & sck_prev;

    // sync_full marks when cs_s reflects the real pin rather than its reset value;
    // only a genuine high level on cs_n arms the slave after reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sck_sync  <= '0;
            cs_sync   <= '1;
            mosi_sync <= '0;
            sync_full <= '0;
            sck_prev  <= 1'b0;
            armed     <= 1'b0;
        end else begin
            sck_sync  <= {sck_sync[SYNC_STAGES-2:0], spi_sck};
            cs_sync   <= {cs_sync[SYNC_STAGES-2:0], spi_cs_n};
            mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], spi_mosi};
            sync_full <= {sync_full[SYNC_STAGES-2:0], 1'b1};
            sck_prev  <= sck_s;
            armed     <= armed | (cs_s & sync_full[SYNC_STAGES-1]);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            bit_cnt   <= '0;
            cmd_sr    <= '0;
            data_sr   <= '0;
            miso_sr   <= '0;
            spi_miso  <= 1'b0;
            spi_wr    <= 1'b0;
            spi_op    <= '0;
            spi_din   <= '0;
            frame_err <= 1'b0;
        end else begin
            spi_wr    <= 1'b0;
            frame_err <= spi_wr & ~spi_ack;
            case (state)
                IDLE: begin
                    bit_cnt  <= '0;
                    spi_miso <= 1'b0;
                    if (!cs_s && armed) state <= CMD;
                end
                CMD: begin
                    if (cs_s) begin
                        state     <= IDLE;
                        frame_err <= 1'b1;
                    end else if (sck_rise) begin
                        cmd_sr  <= {cmd_sr[6:0], mosi_s};
                        bit_cnt <= bit_cnt + 5'd1;
                        if (bit_cnt == 5'd7) begin
                            state   <= DATA;
                            miso_sr <= spi_dout;
                        end
                    end
                end
                DATA: begin
                    if (cs_s) begin
                        state     <= IDLE;
                        frame_err <= 1'b1;
                        spi_miso  <= 1'b0;
                    end else if (sck_rise) begin
                        data_sr <= {data_sr[14:0], mosi_s};
                        if (bit_cnt != 5'd24) bit_cnt <= bit_cnt + 5'd1;
                        if (bit_cnt == 5'd23) begin
                            state    <= HOLD;
                            spi_miso <= 1'b0;
                            if (cmd_sr[7]) begin
                                spi_wr  <= 1'b1;
                                spi_op  <= cmd_sr[6:0];
                                spi_din <= {data_sr[14:0], mosi_s};
                            end
                        end
                    end else if (sck_fall) begin
                        spi_miso <= miso_sr[15];
                        miso_sr  <= {miso_sr[14:0], 1'b0};
                    end
                end
                HOLD: begin
                    spi_miso <= 1'b0;
                    if (cs_s) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_spi_frame_slave.sv
// Directed bench for spi_frame_slave: a master model drives frames while a
// scoreboard of expected register writes is matched against spi_wr strobes.
`timescale 1ns/1ps
module tb_spi_frame_slave;

    localparam int HALF = 60;

    logic        clk = 1'b0;
    logic        rst;
    logic        spi_sck;
    logic        spi_cs_n;
    logic        spi_mosi;
    logic        spi_miso;
    logic        spi_wr;
    logic [6:0]  spi_op;
    logic [15:0] spi_din;
    logic        spi_ack;
    logic [15:0] spi_dout;
    logic        frame_err;

    logic        extra_mosi;
    logic [22:0] exp_q[$];
    int          checks = 0;
    int          fails = 0;
    int          wr_count = 0;
    int          err_count = 0;
    logic        chk_err_next = 1'b0;
    logic        exp_err_next = 1'b0;

    spi_frame_slave #(.SYNC_STAGES(2)) dut (
        .clk(clk), .rst(rst), .spi_sck(spi_sck), .spi_cs_n(spi_cs_n),
        .spi_mosi(spi_mosi), .spi_miso(spi_miso), .spi_wr(spi_wr),
        .spi_op(spi_op), .spi_din(spi_din), .spi_ack(spi_ack),
        .spi_dout(spi_dout), .frame_err(frame_err)
    );

    always #5 clk = ~clk;

    task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            fails++;
            $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Strobes are matched against the scoreboard; the cycle after each strobe
    // must show frame_err exactly when the bench held spi_ack low.
    always @(negedge clk) begin
        logic [22:0] e;
        if (chk_err_next) begin
            check_output("err_after_wr", {31'd0, frame_err}, {31'd0, exp_err_next});
            chk_err_next = 1'b0;
        end
        if (rst && frame_err) err_count++;
        if (rst && spi_wr) begin
            wr_count++;
            chk_err_next = 1'b1;
            exp_err_next = ~spi_ack;
            if (exp_q.size() == 0) begin
                check_output("unexpected_wr", 32'd1, 32'd0);
            end else begin
                e = exp_q.pop_front();
                check_output("spi_op", {25'd0, spi_op}, {25'd0, e[22:16]});
                check_output("spi_din", {16'd0, spi_din}, {16'd0, e[15:0]});
            end
        end
    end

    task automatic shift_bits(input logic [23:0] bits, input int first, input int last,
                              output logic [15:0] rx, output logic cmd_hi, output logic post_hi);
        rx = '0;
        cmd_hi = 1'b0;
        post_hi = 1'b0;
        for (int i = first; i < last; i++) begin
            spi_mosi = (i < 24) ? bits[23 - i] : extra_mosi;
            #(HALF);
            if (i < 8) cmd_hi = cmd_hi | spi_miso;
            else if (i < 24) rx[23 - i] = spi_miso;
            else post_hi = post_hi | spi_miso;
            spi_sck = 1'b1;
            #(HALF);
            spi_sck = 1'b0;
        end
    endtask

    task automatic apply_frame(input logic [7:0] cmd, input logic [15:0] data, input int nbits,
                               output logic [15:0] rx, output logic cmd_hi, output logic post_hi);
        spi_cs_n = 1'b0;
        shift_bits({cmd, data}, 0, nbits, rx, cmd_hi, post_hi);
        #(HALF);
        spi_cs_n = 1'b1;
        #(4 * HALF);
    endtask

    initial begin
        logic [15:0] rx;
        logic        cmd_hi;
        logic        post_hi;
        int          wr0;
        int          err0;

        rst        = 1'b0;
        spi_sck    = 1'b0;
        spi_cs_n   = 1'b1;
        spi_mosi   = 1'b0;
        spi_ack    = 1'b1;
        spi_dout   = 16'h0000;
        extra_mosi = 1'b1;
        #23;
        check_output("rst_spi_wr", {31'd0, spi_wr}, 32'd0);
        check_output("rst_spi_op", {25'd0, spi_op}, 32'd0);
        check_output("rst_spi_din", {16'd0, spi_din}, 32'd0);
        check_output("rst_spi_miso", {31'd0, spi_miso}, 32'd0);
        check_output("rst_frame_err", {31'd0, frame_err}, 32'd0);
        rst = 1'b1;
        #100;

        // Basic acknowledged write.
        wr0 = wr_count; err0 = err_count;
        exp_q.push_back({7'h02, 16'hA5C3});
        apply_frame(8'h82, 16'hA5C3, 24, rx, cmd_hi, post_hi);
        check_output("write_wr_count", wr_count - wr0, 32'd1);
        check_output("write_err_count", err_count - err0, 32'd0);

        // Read frame shifts spi_dout out MSB first, command phase stays quiet.
        spi_dout = 16'h1234;
        wr0 = wr_count; err0 = err_count;
        apply_frame(8'h00, 16'h0000, 24, rx, cmd_hi, post_hi);
        check_output("read_miso_word", {16'd0, rx}, 32'h1234);
        check_output("read_miso_cmd_phase", {31'd0, cmd_hi}, 32'd0);
        check_output("read_wr_count", wr_count - wr0, 32'd0);
        check_output("read_err_count", err_count - err0, 32'd0);
        check_output("hold_op", {25'd0, spi_op}, 32'h02);
        check_output("hold_din", {16'd0, spi_din}, 32'hA5C3);

        // Abort after 13 bits, then a full write must decode cleanly.
        wr0 = wr_count; err0 = err_count;
        apply_frame(8'h85, 16'h1111, 13, rx, cmd_hi, post_hi);
        check_output("abort_wr_count", wr_count - wr0, 32'd0);
        check_output("abort_err_count", err_count - err0, 32'd1);
        wr0 = wr_count; err0 = err_count;
        exp_q.push_back({7'h30, 16'hFFFF});
        apply_frame(8'hB0, 16'hFFFF, 24, rx, cmd_hi, post_hi);
        check_output("after_abort_wr_count", wr_count - wr0, 32'd1);
        check_output("after_abort_err_count", err_count - err0, 32'd0);
        check_output("after_abort_op", {25'd0, spi_op}, 32'h30);
        check_output("after_abort_din", {16'd0, spi_din}, 32'hFFFF);

        // 30 SCK cycles with ones on MOSI past bit 24 and all-ones read data.
        spi_dout = 16'hFFFF;
        wr0 = wr_count; err0 = err_count;
        exp_q.push_back({7'h11, 16'hBEEF});
        apply_frame(8'h91, 16'hBEEF, 30, rx, cmd_hi, post_hi);
        check_output("long_wr_count", wr_count - wr0, 32'd1);
        check_output("long_miso_after_24", {31'd0, post_hi}, 32'd0);
        check_output("long_miso_word", {16'd0, rx}, 32'hFFFF);
        check_output("long_err_count", err_count - err0, 32'd0);

        // Unacknowledged write.
        spi_ack = 1'b0;
        wr0 = wr_count; err0 = err_count;
        exp_q.push_back({7'h05, 16'h0F0F});
        apply_frame(8'h85, 16'h0F0F, 24, rx, cmd_hi, post_hi);
        check_output("nack_wr_count", wr_count - wr0, 32'd1);
        check_output("nack_err_count", err_count - err0, 32'd1);
        spi_ack = 1'b1;

        // Reset at bit 10 with cs_n held low; the tail of that frame must be ignored.
        wr0 = wr_count;
        spi_cs_n = 1'b0;
        shift_bits(24'hC4_7777, 0, 10, rx, cmd_hi, post_hi);
        rst = 1'b0;
        #47;
        rst = 1'b1;
        #20;
        shift_bits(24'hC4_7777, 10, 24, rx, cmd_hi, post_hi);
        #(HALF);
        spi_cs_n = 1'b1;
        #(4 * HALF);
        check_output("rst_mid_wr_count", wr_count - wr0, 32'd0);
        wr0 = wr_count; err0 = err_count;
        exp_q.push_back({7'h44, 16'h9ABC});
        apply_frame(8'hC4, 16'h9ABC, 24, rx, cmd_hi, post_hi);
        check_output("post_rst_wr_count", wr_count - wr0, 32'd1);
        check_output("post_rst_err_count", err_count - err0, 32'd0);

        check_output("scoreboard_empty", exp_q.size(), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule

// File: doc/spi_frame_slave.md
SPI_FRAME_SLAVE -- requirements
Module: spi_frame_slave

Interface
REQ-001 SHALL have parameter SYNC_STAGES, default 2, meaning the number of flip-flop stages used to synchronize spi_sck, spi_cs_n and spi_mosi into clk (legal values 2..3).
REQ-002 SHALL have port clk  input  1  system clock; all logic is rising-edge clocked.
REQ-003 SHALL have port rst  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port spi_sck  input  1  external SPI clock, mode 0 (CPOL=0, CPHA=0), asynchronous to clk.
REQ-005 SHALL have port spi_cs_n  input  1  external chip select, active-low, asynchronous to clk.
REQ-006 SHALL have port spi_mosi  input  1  external serial data in, MSB first.
REQ-007 SHALL have port spi_miso  output  1  serial data out, MSB first; driven to 0 (no tristate) outside the data phase.
REQ-008 SHALL have port spi_wr  output  1  one-clk write strobe to the register controller.
REQ-009 SHALL have port spi_op  output  7  register opcode; valid while spi_wr=1.
REQ-010 SHALL have port spi_din  output  16  write data; valid while spi_wr=1.
REQ-011 SHALL have port spi_ack  input  1  register controller acknowledge; expected high in the same cycle as spi_wr.
REQ-012 SHALL have port spi_dout  input  16  read data from the register controller.
REQ-013 SHALL have port frame_err  output  1  one-clk pulse on an aborted or unacknowledged frame.

Function
REQ-014 Frame format: cs_n falls; 8 command bits (bit7 = W flag, bits6:0 = op); 16 data bits; cs_n rises.
REQ-015 Sampling: spi_mosi SHALL be sampled on the detected synchronized rising edge of spi_sck; spi_miso SHALL update on the detected synchronized falling edge.
REQ-016 Timing: SCK high and low times SHALL each be at least SYNC_STAGES+2 clk periods. Behaviour outside this limit is undefined.
REQ-017 FSM states: IDLE, CMD, DATA, HOLD.
REQ-018 FSM transitions: IDLE->CMD when synchronized cs_n is low; CMD->DATA after the 8th rising edge; DATA->HOLD after the 24th rising edge; any state->IDLE when synchronized cs_n is high.
REQ-019 Bit counter: 5 bits, cleared in IDLE, incremented on each rising edge in CMD/DATA, saturating at 24; it never wraps.
REQ-020 On the 8th rising edge, spi_dout SHALL be latched into a 16-bit shift register; bit15 SHALL drive spi_miso from the following falling edge, one bit per falling edge thereafter.
REQ-021 When the W flag is 1, spi_wr SHALL pulse for exactly one clk, on the cycle after the 24th rising edge is detected, with spi_op=cmd[6:0] and spi_din=the 16 data bits.
REQ-022 When the W flag is 0, there SHALL be no spi_wr pulse; the frame is read-only and only shifts out spi_dout.
REQ-023 spi_op and spi_din SHALL hold their last values between strobes.
REQ-024 HOLD: further SCK edges SHALL be ignored, no additional spi_wr is issued, and spi_miso=0 until cs_n rises.
REQ-025 Abort: if cs_n rises in CMD or DATA (fewer than 24 bits), there SHALL be no spi_wr, a one-clk frame_err pulse, and a return to IDLE.
REQ-026 If spi_ack=0 in the spi_wr cycle, frame_err SHALL pulse one clk, in the cycle after spi_wr.
REQ-027 cs_n falling directly again after rising SHALL start a fresh frame with the counter cleared; there SHALL be no carry-over of bits.
REQ-028 spi_cs_n and spi_mosi SHALL pass through the same SYNC_STAGES as spi_sck so that all three see equal latency.

Reset
REQ-029 While rst=0: state=IDLE, bit counter=0, shift registers=0, spi_wr=0, spi_op=0, spi_din=0, spi_miso=0, frame_err=0; the synchronizer flops SHALL reset to sck=0 and cs_n=1.
REQ-030 Reset deasserted mid-frame (cs_n already low): the block SHALL wait for a cs_n high level before accepting a frame, so no partial-frame strobe is possible.

Verification
REQ-031 Write frame cmd=0x82, data=0xA5C3, spi_ack=1 -> exactly one spi_wr pulse with spi_op=0x02, spi_din=0xA5C3, and frame_err=0.
REQ-032 Read frame cmd=0x00, data=0x0000, spi_dout=0x1234 stable -> spi_miso bits over the data phase are 0x1234 MSB first, no spi_wr, and spi_miso=0 during the command phase.
REQ-033 cs_n raised after 13 bits -> no spi_wr, one frame_err pulse; the next full write frame cmd=0xB0, data=0xFFFF yields spi_op=0x30, spi_din=0xFFFF.
REQ-034 Write frame with 30 SCK cycles -> one spi_wr only, spi_din taken from bits 8..23, and spi_miso=0 after bit 24.
REQ-035 Write frame with spi_ack tied 0 -> spi_wr pulse followed next cycle by a frame_err pulse.
REQ-036 rst asserted at bit 10 and released with cs_n still low, remaining bits clocked -> no spi_wr; the next full frame decodes correctly.
